fpa_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one floating-point adder among `NREQ` requesters. It accepts operand pairs plus an add/subtract select from each requester and drives the adder's start/done handshake. It routes the result back to the requester that issued the operation. It sits between the client blocks and the adder's datapath/controller pair, and owns the adder's start and reset lines.

---
 rtl/fpa_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fpa_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpa_arbiter.sv
// fpa_arbiter: round-robin sequencer sharing one FP adder among NREQ clients.
// Optional watchdog abort is built in when FPA_ARB_WDOG_EN is defined.
module fpa_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 32,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ-1:0]       op_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  fpa_start,
    output logic                  fpa_rst,
    output logic [WIDTH-1:0]      fpa_a,
    output logic [WIDTH-1:0]      fpa_b,
    output logic                  fpa_op,
    input  logic                  fpa_done,
    input  logic [WIDTH-1:0]      fpa_result
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef FPA_ARB_WDOG_EN
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_LAUNCH, S_BUSY, S_RESP, S_ABORT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ISSUE, S_LAUNCH, S_BUSY, S_RESP
    } state_t;
`endif

    state_t state, state_d;
    logic [IW-1:0] ptr, idx, idx_d, win, cand, ptr_nx;
    logic found, take, resp_d, frst_d;
    logic [NREQ-1:0] oh_d;

    // first set request at or above ptr, wrapping
    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign ptr_nx = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    assign take   = (state == S_IDLE) && fpa_done && found;
    assign idx_d  = take ? win : idx;

    always_comb begin
        oh_d        = '0;
        oh_d[idx_d] = 1'b1;
    end

`ifdef FPA_ARB_WDOG_EN
    localparam int CW = ($clog2(WDOG_CYCLES + 1) > 8) ?
                        $clog2(WDOG_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    logic          wdog_hit;

    // fires on the WDOG_CYCLES-th cycle spent in LAUNCH/BUSY
    assign wdog_hit = (cnt == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= (state_d == S_ABORT);
            if (state == S_ISSUE)
                cnt <= '0;
            else if (state == S_LAUNCH || state == S_BUSY)
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            S_INIT:   state_d = S_IDLE;
            S_IDLE:   if (take) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_LAUNCH;
            S_LAUNCH: begin
                if (!fpa_done) state_d = S_BUSY;
`ifdef FPA_ARB_WDOG_EN
                else if (wdog_hit) state_d = S_ABORT;
`endif
            end
            S_BUSY: begin
                if (fpa_done) state_d = S_RESP;
`ifdef FPA_ARB_WDOG_EN
                else if (wdog_hit) state_d = S_ABORT;
`endif
            end
            S_RESP:   state_d = S_IDLE;
`ifdef FPA_ARB_WDOG_EN
            S_ABORT:  state_d = S_IDLE;
`endif
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        resp_d = (state_d == S_RESP);
        frst_d = (state_d == S_INIT);
`ifdef FPA_ARB_WDOG_EN
        resp_d = resp_d || (state_d == S_ABORT);
        frst_d = frst_d || (state_d == S_ABORT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            ptr       <= '0;
            idx       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b1;
            fpa_start <= 1'b0;
            fpa_rst   <= 1'b1;
            fpa_a     <= '0;
            fpa_b     <= '0;
            fpa_op    <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            gnt       <= (state_d == S_ISSUE) ? oh_d : '0;
            rsp_valid <= resp_d ? oh_d : '0;
            busy      <= (state_d != S_IDLE);
            fpa_start <= (state_d == S_ISSUE);
            fpa_rst   <= frst_d;
            if (take) begin
                ptr    <= ptr_nx;
                fpa_a  <= a_in[int'(win)*WIDTH +: WIDTH];
                fpa_b  <= b_in[int'(win)*WIDTH +: WIDTH];
                fpa_op <= op_in[win];
            end
            if (state == S_BUSY && fpa_done)
                rsp_data <= fpa_result;
`ifdef FPA_ARB_WDOG_EN
            else if (state_d == S_ABORT)
                rsp_data <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_fpa_arbiter.sv
// tb_fpa_arbiter: vector table plus scoreboard bench for fpa_arbiter.
// Watchdog sequence is included when FPA_ARB_WDOG_EN is defined.
module tb_fpa_arbiter;
    localparam int N = 4;
    localparam int W = 32;
`ifdef FPA_ARB_WDOG_EN
    localparam int WD = 16;
`else
    localparam int WD = 255;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, op_in, gnt, rsp_valid;
    logic [N*W-1:0] a_in, b_in;
    logic [W-1:0]   rsp_data, fpa_a, fpa_b, fpa_result;
    logic           rsp_err, busy, fpa_start, fpa_rst, fpa_op, fpa_done;

    fpa_arbiter #(.NREQ(N), .WIDTH(W), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .op_in(op_in), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .fpa_start(fpa_start), .fpa_rst(fpa_rst), .fpa_a(fpa_a),
        .fpa_b(fpa_b), .fpa_op(fpa_op), .fpa_done(fpa_done),
        .fpa_result(fpa_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // single precision <-> real, normal numbers and zero only
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // adder model: done is a level, low from start until result ready
    logic        hang;
    int          lat, ph, left;
    logic [31:0] res_q;
    always @(posedge clk) begin
        if (fpa_rst) begin
            fpa_done <= 1'b1;
            ph       <= 0;
        end else begin
            case (ph)
                0: if (fpa_start) begin
                    fpa_done <= 1'b0;
                    ph       <= 1;
                    res_q    <= r2sp(fpa_op ? sp2r(fpa_a) - sp2r(fpa_b)
                                            : sp2r(fpa_a) + sp2r(fpa_b));
                end
                1: if (!fpa_start) begin
                    ph   <= 2;
                    left <= lat;
                end
                default: if (!hang) begin
                    if (left == 0) begin
                        fpa_done   <= 1'b1;
                        fpa_result <= res_q;
                        ph         <= 0;
                    end else begin
                        left <= left - 1;
                    end
                end
            endcase
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        err;
    } op_t;

    op_t  gq[$];
    op_t  rq[$];
    op_t  cur, rr;
    logic inflight = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            inflight = 1'b0;
        end else begin
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexp", gnt, 0);
                end else begin
                    cur = gq.pop_front();
                    chk("gnt_idx", gnt, N'(1) << cur.idx);
                    chk("gnt_overlap", inflight, 0);
                    chk("gnt_start", fpa_start, 1);
                    inflight = 1'b1;
                end
            end
            if (inflight) begin
                chk("hold_a", fpa_a, cur.a);
                chk("hold_b", fpa_b, cur.b);
                chk("hold_op", fpa_op, cur.op);
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexp", rsp_valid, 0);
                end else begin
                    rr = rq.pop_front();
                    chk("rsp_idx", rsp_valid, N'(1) << rr.idx);
                    chk("rsp_data", rsp_data, rr.res);
                    chk("rsp_err", rsp_err, rr.err);
                    chk("rsp_fpa_rst", fpa_rst, rr.err);
                end
                inflight = 1'b0;
            end
        end
    end

    task automatic drive(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic op);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
        op_in[i]       = op;
        req[i]         = 1'b1;
    endtask

    task automatic expect_op(input int i, input logic [31:0] a,
                             input logic [31:0] b, input logic op,
                             input logic [31:0] res, input logic err);
        op_t e;
        e.idx = i; e.a = a; e.b = b; e.op = op; e.res = res; e.err = err;
        gq.push_back(e);
        rq.push_back(e);
    endtask

    task automatic send(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic op,
                        input logic [31:0] res, input logic err);
        expect_op(i, a, b, op, res, err);
        drive(i, a, b, op);
    endtask

    task automatic wait_gnt(input int i, input bit drop, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < 200);
        chk("gnt_seen", gnt[i], 1);
        at = cyc;
        if (drop) req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rq.size() != 0 || busy) && n < 300);
        chk("drain_q", rq.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 1);
        chk("rst_fpa_rst", fpa_rst, 1);
        chk("rst_ctl", {gnt, rsp_valid, rsp_err, fpa_start, fpa_op}, 0);
        chk("rst_fpa_a", fpa_a, 0);
        chk("rst_fpa_b", fpa_b, 0);
        chk("rst_data", rsp_data, 0);
    endtask

    task automatic chk_init_exit();
        @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_fpa_rst", fpa_rst, 0);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[6];
    int   t;
    logic seen;

    initial begin
        tbl[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
        tbl[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
        tbl[2] = '{1, 32'h40800000, 32'h40000000, 1'b1, 32'h40000000};
        tbl[3] = '{3, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000};
        tbl[4] = '{0, 32'h41200000, 32'hC0A00000, 1'b0, 32'h40A00000};
        tbl[5] = '{2, 32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000};

        rst   = 1'b1;
        req   = '0;
        op_in = '0;
        a_in  = '0;
        b_in  = '0;
        hang  = 1'b0;
        lat   = 3;
        #1 rst = 1'b0;

        // all four requests held from reset
        send(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
        send(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
        send(2, 32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 1'b0);
        send(3, 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 1'b0);
        expect_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
        #1 chk_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_init_exit();
        wait_gnt(0, 1'b0, t);
        wait_gnt(1, 1'b0, t);
        wait_gnt(2, 1'b0, t);
        wait_gnt(3, 1'b0, t);
        wait_gnt(0, 1'b0, t);
        req = '0;
        wait_idle();

        for (int k = 0; k < 6; k++) begin
            send(tbl[k].idx, tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].res, 1'b0);
            wait_gnt(tbl[k].idx, 1'b1, t);
            wait_idle();
        end

        // pointer wrap after serving 3
        send(3, 32'h41000000, 32'h40800000, 1'b1, 32'h40800000, 1'b0);
        wait_gnt(3, 1'b1, t);
        wait_idle();
        send(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
        send(3, 32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1'b0);
        wait_gnt(1, 1'b1, t);
        wait_gnt(3, 1'b1, t);
        wait_idle();

        // request withdrawn before any IDLE cycle is never granted
        send(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        wait_gnt(0, 1'b1, t);
        @(negedge clk);
        req[2] = 1'b1;
        @(negedge clk);
        req[2] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen = seen | gnt[2];
        end
        wait_idle();
        chk("drop_nogrant", seen, 0);

        // asynchronous reset while the adder is busy
        send(1, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 1'b0);
        wait_gnt(1, 1'b1, t);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset();
        gq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        chk("rst_hold_busy", busy, 1);
        rst = 1'b1;
        chk_init_exit();
        send(0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
        send(3, 32'h41000000, 32'h3F800000, 1'b1, 32'h40E00000, 1'b0);
        wait_gnt(0, 1'b1, t);
        wait_gnt(3, 1'b1, t);
        wait_idle();

`ifdef FPA_ARB_WDOG_EN
        hang = 1'b1;
        send(2, 32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 1'b1);
        wait_gnt(2, 1'b1, t);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (rsp_valid == '0 && n < WD + 40);
        end
        chk("wdog_rsp", rsp_valid, 4'b0100);
        chk("wdog_lat", cyc - t, WD + 1);
        chk("wdog_frst", fpa_rst, 1);
        hang = 1'b0;
        @(negedge clk);
        chk("wdog_frst_pulse", fpa_rst, 0);
        wait_idle();
        send(1, 32'h40400000, 32'h40000000, 1'b0, 32'h40A00000, 1'b0);
        wait_gnt(1, 1'b1, t);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got running want finished");
        $fatal(1, "time limit");
    end

endmodule
